// File: rtl/moesi_mem_bridge.sv
// rtl/moesi_mem_bridge.sv - coherency bus to shared memory bridge, one transaction in flight
module moesi_mem_bridge #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = 64,
  parameter int DATA_WIDTH = LINE_BYTES * 8,
  localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bus_valid,
  input  logic [1:0]            i_bus_type,
  input  logic [ADDR_WIDTH-1:0] i_bus_addr,
  input  logic [ID_W-1:0]       i_granted_core_id,
  input  logic [NUM_CORES-1:0]  i_snoop_resp,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_busy,
  output logic                  o_mem_req_valid,
  output logic                  o_mem_req_write,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_resp_rdata,
  output logic                  o_fill_valid,
  output logic [ID_W-1:0]       o_fill_core_id,
  output logic [DATA_WIDTH-1:0] o_fill_data,
  output logic                  o_drop_err,
  output logic [15:0]           o_rd_count,
  output logic [15:0]           o_wb_count
);

  localparam logic [1:0] BUS_RD  = 2'b01;
  localparam logic [1:0] BUS_RDX = 2'b10;
  localparam logic [1:0] BUS_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FILL     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ID_W-1:0]       r_core_id;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic                  r_drop_err;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wb_count;

  logic                  w_accept;
  logic                  w_is_rd;
  logic                  w_is_wb;
  logic [NUM_CORES-1:0]  w_own_mask;
  logic                  w_peer_hit;
  logic                  w_handshake;
  logic [ADDR_WIDTH-1:0] w_line_addr;

  // The requester's own snoop bit never counts as a supplier.
  assign w_own_mask  = {{(NUM_CORES-1){1'b0}}, 1'b1} << i_granted_core_id;
  assign w_peer_hit  = |(i_snoop_resp & ~w_own_mask);
  assign w_is_rd     = (i_bus_type == BUS_RD) || (i_bus_type == BUS_RDX);
  assign w_is_wb     = (i_bus_type == BUS_WB);
  assign w_accept    = i_bus_valid && (r_state == ST_IDLE);
  assign w_handshake = (r_state == ST_MEM_REQ) && i_mem_req_ready;
  assign w_line_addr = i_bus_addr & ~(ADDR_WIDTH'(LINE_BYTES - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; peer-supplied reads and upgrades never leave IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    o_busy          = (r_state != ST_IDLE);
    o_mem_req_valid = (r_state == ST_MEM_REQ);
    o_fill_valid    = (r_state == ST_FILL);
    case (r_state)
      ST_IDLE: begin
        if (i_bus_valid && (w_is_wb || (w_is_rd && !w_peer_hit))) w_state_nxt = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        if (i_mem_req_ready) w_state_nxt = r_write ? ST_IDLE : ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (i_mem_resp_valid) w_state_nxt = ST_FILL;
      end
      ST_FILL: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction capture, fill data, sticky drop flag and saturating counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_core_id   <= '0;
      r_fill_data <= '0;
      r_drop_err  <= 1'b0;
      r_rd_count  <= '0;
      r_wb_count  <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= w_line_addr;
        r_write   <= w_is_wb;
        r_core_id <= i_granted_core_id;
        if (w_is_wb) r_wdata <= i_wb_data;
      end
      if (i_bus_valid && (r_state != ST_IDLE)) r_drop_err <= 1'b1;
      if ((r_state == ST_MEM_WAIT) && i_mem_resp_valid) r_fill_data <= i_mem_resp_rdata;
      if (w_handshake && !r_write && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
      if (w_handshake &&  r_write && (r_wb_count != 16'hFFFF)) r_wb_count <= r_wb_count + 16'd1;
    end
  end

  assign o_mem_req_write = r_write;
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_wdata = r_wdata;
  assign o_fill_core_id  = r_core_id;
  assign o_fill_data     = r_fill_data;
  assign o_drop_err      = r_drop_err;
  assign o_rd_count      = r_rd_count;
  assign o_wb_count      = r_wb_count;

endmodule

// File: tb/tb_moesi_mem_bridge.sv
// tb/tb_moesi_mem_bridge.sv - self-checking bench for moesi_mem_bridge
module tb_moesi_mem_bridge;

  logic         clk;
  logic         rst;
  logic         bus_valid;
  logic [1:0]   bus_type;
  logic [63:0]  bus_addr;
  logic [1:0]   core_id;
  logic [3:0]   snoop;
  logic [511:0] wb_data;
  logic         o_busy;
  logic         o_mem_req_valid;
  logic         o_mem_req_write;
  logic [63:0]  o_mem_req_addr;
  logic [511:0] o_mem_req_wdata;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [511:0] mem_resp_rdata;
  logic         o_fill_valid;
  logic [1:0]   o_fill_core_id;
  logic [511:0] o_fill_data;
  logic         o_drop_err;
  logic [15:0]  o_rd_count;
  logic [15:0]  o_wb_count;

  moesi_mem_bridge dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_bus_valid       (bus_valid),
    .i_bus_type        (bus_type),
    .i_bus_addr        (bus_addr),
    .i_granted_core_id (core_id),
    .i_snoop_resp      (snoop),
    .i_wb_data         (wb_data),
    .o_busy            (o_busy),
    .o_mem_req_valid   (o_mem_req_valid),
    .o_mem_req_write   (o_mem_req_write),
    .o_mem_req_addr    (o_mem_req_addr),
    .o_mem_req_wdata   (o_mem_req_wdata),
    .i_mem_req_ready   (mem_req_ready),
    .i_mem_resp_valid  (mem_resp_valid),
    .i_mem_resp_rdata  (mem_resp_rdata),
    .o_fill_valid      (o_fill_valid),
    .o_fill_core_id    (o_fill_core_id),
    .o_fill_data       (o_fill_data),
    .o_drop_err        (o_drop_err),
    .o_rd_count        (o_rd_count),
    .o_wb_count        (o_wb_count)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [63:0] addr;
    logic [1:0]  core;
    logic [3:0]  snoop;
    logic [7:0]  pat;
    int          lat;
    int          stall;
    bit          exp_mem;
    bit          exp_write;
    logic [63:0] exp_addr;
  } vec_t;

  typedef struct {
    logic         write;
    logic [63:0]  addr;
    logic [511:0] wdata;
    int           stall;
  } exp_req_t;

  typedef struct {
    logic [1:0]   core;
    logic [511:0] data;
  } exp_fill_t;

  exp_req_t  req_q[$];
  exp_fill_t fill_q[$];
  vec_t      vecs[8];

  int          checks = 0;
  int          errors = 0;
  int          held   = 0;
  logic        prev_resp = 1'b0;
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] exp_wb = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare memory requests and fills against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_req_valid) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr %0h expected no request", o_mem_req_addr);
        end else begin
          check("req_addr", o_mem_req_addr, req_q[0].addr);
          check("req_write", o_mem_req_write, req_q[0].write);
          if (req_q[0].write) check("req_wdata", o_mem_req_wdata, req_q[0].wdata);
          held++;
          if (mem_req_ready) begin
            check("req_hold_cycles", held, req_q[0].stall + 1);
            held = 0;
            void'(req_q.pop_front());
          end
        end
      end
      if (o_fill_valid) begin
        if (fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fill_unexpected: got core %0d expected no fill", o_fill_core_id);
        end else begin
          check("fill_core_id", o_fill_core_id, fill_q[0].core);
          check("fill_data", o_fill_data, fill_q[0].data);
          check("fill_after_resp", prev_resp, 1'b1);
          void'(fill_q.pop_front());
        end
      end
    end
    prev_resp = mem_resp_valid;
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_req_t  er;
    exp_fill_t ef;
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_type = v.typ; bus_addr = v.addr; core_id = v.core;
    snoop = v.snoop; wb_data = {64{v.pat}}; mem_req_ready = 1'b0;
    if (v.exp_mem) begin
      er.write = v.exp_write; er.addr = v.exp_addr;
      er.wdata = {64{v.pat}}; er.stall = v.stall;
      req_q.push_back(er);
    end
    @(posedge clk); #1;
    bus_valid = 1'b0;
    check("req_valid_after_accept", o_mem_req_valid, v.exp_mem);
    check("busy_after_accept", o_busy, v.exp_mem);
    if (!v.exp_mem) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("busy_no_mem", o_busy, 1'b0);
      end
    end else begin
      for (int i = 0; i < v.stall; i++) begin
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (v.exp_write) begin
        check("busy_after_wb", o_busy, 1'b0);
        exp_wb = sat_inc(exp_wb);
      end else begin
        check("busy_mem_wait", o_busy, 1'b1);
        exp_rd = sat_inc(exp_rd);
        for (int i = 0; i < v.lat - 1; i++) begin
          @(posedge clk); #1;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {64{v.pat ^ 8'hFF}};
        ef.core = v.core; ef.data = {64{v.pat ^ 8'hFF}};
        fill_q.push_back(ef);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        check("fill_valid_timing", o_fill_valid, 1'b1);
        @(posedge clk); #1;
        check("fill_one_cycle", o_fill_valid, 1'b0);
        check("busy_after_fill", o_busy, 1'b0);
      end
    end
    check("rd_count", o_rd_count, exp_rd);
    check("wb_count", o_wb_count, exp_wb);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_req_valid"}, o_mem_req_valid, 1'b0);
    check({tag, "_req_addr"}, o_mem_req_addr, 64'h0);
    check({tag, "_fill_valid"}, o_fill_valid, 1'b0);
    check({tag, "_fill_core"}, o_fill_core_id, 2'd0);
    check({tag, "_fill_data"}, o_fill_data, 512'h0);
    check({tag, "_drop_err"}, o_drop_err, 1'b0);
    check({tag, "_rd_count"}, o_rd_count, 16'h0);
    check({tag, "_wb_count"}, o_wb_count, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_req_t  er;
    exp_fill_t ef;
    vecs[0] = '{2'b01, 64'h1234, 2'd2, 4'b0000, 8'h3C, 4, 0, 1'b1, 1'b0, 64'h1200};
    vecs[1] = '{2'b10, 64'h8888, 2'd0, 4'b0100, 8'h00, 1, 0, 1'b0, 1'b0, 64'h0};
    vecs[2] = '{2'b10, 64'h2000_007F, 2'd0, 4'b0001, 8'h5A, 2, 1, 1'b1, 1'b0, 64'h2000_0040};
    vecs[3] = '{2'b11, 64'h40, 2'd1, 4'b0000, 8'hA5, 1, 3, 1'b1, 1'b1, 64'h40};
    vecs[4] = '{2'b00, 64'h100, 2'd3, 4'b0000, 8'h11, 1, 0, 1'b0, 1'b0, 64'h0};
    vecs[5] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFC1, 2'd1, 4'b1111, 8'hC3, 1, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[6] = '{2'b01, 64'h7, 2'd3, 4'b1000, 8'h96, 1, 2, 1'b1, 1'b0, 64'h0};
    vecs[7] = '{2'b01, 64'h9999, 2'd1, 4'b1010, 8'h00, 1, 0, 1'b0, 1'b0, 64'h0};

    rst = 1'b1; bus_valid = 1'b0; bus_type = 2'b00; bus_addr = '0; core_id = '0;
    snoop = '0; wb_data = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      check("drop_err_clean", o_drop_err, 1'b0);
    end

    // Collision: a second transaction during MEM_WAIT is dropped, first fill still completes.
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_type = 2'b01; bus_addr = 64'h30C5; core_id = 2'd1; snoop = 4'b0000;
    er.write = 1'b0; er.addr = 64'h30C0; er.wdata = '0; er.stall = 0;
    req_q.push_back(er);
    @(posedge clk); #1;
    bus_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    bus_valid = 1'b1; bus_type = 2'b11; bus_addr = 64'h9000; core_id = 2'd3; wb_data = {64{8'hEE}};
    @(posedge clk); #1;
    bus_valid = 1'b0;
    check("drop_err_set", o_drop_err, 1'b1);
    check("busy_still_wait", o_busy, 1'b1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b1; mem_resp_rdata = {64{8'h77}};
    ef.core = 2'd1; ef.data = {64{8'h77}};
    fill_q.push_back(ef);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    check("collision_fill", o_fill_valid, 1'b1);
    @(posedge clk); #1;
    check("collision_idle", o_busy, 1'b0);
    check("drop_err_sticky", o_drop_err, 1'b1);
    exp_rd = sat_inc(exp_rd);
    check("collision_rd_count", o_rd_count, exp_rd);
    check("collision_wb_count", o_wb_count, exp_wb);

    // Reset in MEM_WAIT abandons the read; a late response must not produce a fill.
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_type = 2'b01; bus_addr = 64'h5000; core_id = 2'd2; snoop = 4'b0000;
    er.write = 1'b0; er.addr = 64'h5000; er.wdata = '0; er.stall = 0;
    req_q.push_back(er);
    @(posedge clk); #1;
    bus_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("busy_before_reset", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 16'd0; exp_wb = 16'd0;
    mem_resp_valid = 1'b1; mem_resp_rdata = {64{8'hFF}};
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_reset_no_fill", o_fill_valid, 1'b0);
      check("post_reset_idle", o_busy, 1'b0);
      @(posedge clk); #1;
    end
    check("post_reset_fill_data", o_fill_data, 512'h0);

    // Saturation: preload counters near the top and issue two of each.
    force dut.r_rd_count = 16'hFFFE;
    force dut.r_wb_count = 16'hFFFE;
    #1;
    release dut.r_rd_count;
    release dut.r_wb_count;
    exp_rd = 16'hFFFE; exp_wb = 16'hFFFE;
    run_vec(vecs[0]);
    run_vec(vecs[6]);
    check("rd_saturated", o_rd_count, 16'hFFFF);
    run_vec(vecs[3]);
    run_vec(vecs[5]);
    check("wb_saturated", o_wb_count, 16'hFFFF);

    repeat (2) @(posedge clk);
    #1;
    check("req_queue_drained", req_q.size(), 0);
    check("fill_queue_drained", fill_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
